// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix-keypad scanner.
//   state_e : scanner FSM states
//   key_w() : key-index width for a ROWS x COLS matrix
//   KEY_*   : key indices of the standard 4x3 telephone-style pad
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Width of key_code; a 1-key matrix still needs one bit.
  function automatic int unsigned key_w(input int unsigned rows, input int unsigned cols);
    return (rows * cols > 1) ? 32'($clog2(rows * cols)) : 32'd1;
  endfunction

  localparam int unsigned KEY_1    = 0;
  localparam int unsigned KEY_2    = 1;
  localparam int unsigned KEY_3    = 2;
  localparam int unsigned KEY_4    = 3;
  localparam int unsigned KEY_5    = 4;
  localparam int unsigned KEY_6    = 5;
  localparam int unsigned KEY_7    = 6;
  localparam int unsigned KEY_8    = 7;
  localparam int unsigned KEY_9    = 8;
  localparam int unsigned KEY_STAR = 9;
  localparam int unsigned KEY_0    = 10;
  localparam int unsigned KEY_HASH = 11;

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous column returns.
//   clock   : system clock
//   reset_n : asynchronous active-low reset, clears both stages
//   col_i   : raw column inputs (COLS wide)
//   col_s_o : synchronised columns, 2 cycles of latency
module keypad_col_sync #(
  parameter int unsigned COLS = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [COLS-1:0] col_i,
  output logic [COLS-1:0] col_s_o
);

  logic [COLS-1:0] meta_q;
  logic [COLS-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= col_i;
      sync_q <= meta_q;
    end
  end

  assign col_s_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Debounced matrix-keypad scanner: rotates one-hot row strobes, tracks a
// single key through press debounce, hold (optional auto-repeat) and release
// debounce. All outputs are registered.
//   clock, reset_n : clock, asynchronous active-low reset
//   col            : raw column returns, active-high, asynchronous
//   row            : one-hot row drive
//   key_code       : row_index*COLS + col_index of the last accepted key
//   key_valid      : one-cycle strobe for a new press or a repeat
//   key_repeat     : qualifies key_valid as an auto-repeat
//   key_held       : debounced key currently down
//   key_release    : one-cycle strobe when a release completes
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 3,
  parameter int unsigned SCAN_TICKS     = 5209,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [COLS-1:0]              col,
  output logic [ROWS-1:0]              row,
  output logic [key_w(ROWS, COLS)-1:0] key_code,
  output logic                         key_valid,
  output logic                         key_repeat,
  output logic                         key_held,
  output logic                         key_release
);

  localparam int unsigned KEY_W  = key_w(ROWS, COLS);
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned TICK_W = $clog2(SCAN_TICKS);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned REP_W  = (REPEAT_SCANS > 0) ? $clog2(REPEAT_SCANS + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REPEAT_SCANS);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

  logic [COLS-1:0] col_s;

  keypad_col_sync #(.COLS(COLS)) u_col_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .col_i   (col),
    .col_s_o (col_s)
  );

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [ROWS-1:0]    row_q, row_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic [COL_W-1:0]   cap_col_q, cap_col_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [KEY_W-1:0]   key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               key_repeat_q, key_repeat_d;
  logic               key_held_q, key_held_d;
  logic               key_release_q, key_release_d;

  logic               tick_c;
  logic [COL_W-1:0]   first_col_c;
  logic               cap_hit_c;
  logic [KEY_W-1:0]   new_code_c;
  logic [KEY_W-1:0]   cap_code_c;
  logic [ROWS-1:0]    row_next_c;
  logic [ROW_W-1:0]   row_idx_next_c;
  logic [DEB_W-1:0]   deb_inc_c;
  logic [REP_W-1:0]   rep_inc_c;

  assign tick_c = (tick_cnt_q == TICK_LAST);

  // Lowest-index active column wins when several keys share the row.
  always_comb begin
    first_col_c = '0;
    for (int i = int'(COLS) - 1; i >= 0; i--) begin
      if (col_s[i]) first_col_c = COL_W'(i);
    end
  end

  // Level of the captured column only; other columns are ignored while busy.
  always_comb begin
    cap_hit_c = 1'b0;
    for (int i = 0; i < int'(COLS); i++) begin
      if (COL_W'(i) == cap_col_q) cap_hit_c = col_s[i];
    end
  end

  // Row is frozen outside IDLE, so row_idx_q doubles as the captured row.
  assign new_code_c     = KEY_W'(row_idx_q) * KEY_W'(COLS) + KEY_W'(first_col_c);
  assign cap_code_c     = KEY_W'(row_idx_q) * KEY_W'(COLS) + KEY_W'(cap_col_q);
  assign row_next_c     = {row_q[ROWS-2:0], row_q[ROWS-1]};
  assign row_idx_next_c = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + ROW_W'(1);
  assign deb_inc_c      = deb_cnt_q + DEB_W'(1);
  assign rep_inc_c      = rep_cnt_q + REP_W'(1);

  // Next-state logic; all decisions are taken on a tick.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    row_d         = row_q;
    row_idx_d     = row_idx_q;
    cap_col_d     = cap_col_q;
    deb_cnt_d     = deb_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_repeat_d  = 1'b0;
    key_held_d    = key_held_q;
    key_release_d = 1'b0;

    if (tick_c) begin
      unique case (state_q)
        IDLE: begin
          if (|col_s) begin
            cap_col_d = first_col_c;
            deb_cnt_d = DEB_W'(1);
            rep_cnt_d = '0;
            if (DEBOUNCE_SCANS == 1) begin
              key_code_d  = new_code_c;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            row_d     = row_next_c;
            row_idx_d = row_idx_next_c;
          end
        end

        DEBOUNCE: begin
          if (cap_hit_c) begin
            deb_cnt_d = deb_inc_c;
            if (deb_inc_c == DEB_MAX) begin
              key_code_d  = cap_code_c;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rep_cnt_d   = '0;
              state_d     = HELD;
            end
          end else begin
            deb_cnt_d = '0;
            row_d     = row_next_c;
            row_idx_d = row_idx_next_c;
            state_d   = IDLE;
          end
        end

        HELD: begin
          if (cap_hit_c) begin
            if (REPEAT_SCANS != 0) begin
              if (rep_inc_c == REP_MAX) begin
                key_valid_d  = 1'b1;
                key_repeat_d = 1'b1;
                rep_cnt_d    = '0;
              end else begin
                rep_cnt_d = rep_inc_c;
              end
            end
          end else begin
            rep_cnt_d = '0;
            if (DEBOUNCE_SCANS == 1) begin
              // A single low tick already completes the release.
              deb_cnt_d     = '0;
              key_held_d    = 1'b0;
              key_release_d = 1'b1;
              row_d         = row_next_c;
              row_idx_d     = row_idx_next_c;
              state_d       = IDLE;
            end else begin
              deb_cnt_d = DEB_W'(1);
              state_d   = RELEASE;
            end
          end
        end

        RELEASE: begin
          if (!cap_hit_c) begin
            deb_cnt_d = deb_inc_c;
            if (deb_inc_c == DEB_MAX) begin
              deb_cnt_d     = '0;
              key_held_d    = 1'b0;
              key_release_d = 1'b1;
              row_d         = row_next_c;
              row_idx_d     = row_idx_next_c;
              state_d       = IDLE;
            end
          end else begin
            deb_cnt_d = '0;
            state_d   = HELD;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      row_q         <= ROWS'(1);
      row_idx_q     <= '0;
      cap_col_q     <= '0;
      deb_cnt_q     <= '0;
      rep_cnt_q     <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_repeat_q  <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      row_q         <= row_d;
      row_idx_q     <= row_idx_d;
      cap_col_q     <= cap_col_d;
      deb_cnt_q     <= deb_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_repeat_q  <= key_repeat_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
    end
  end

  assign row         = row_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_repeat  = key_repeat_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (ROWS=4, COLS=3, SCAN_TICKS=8,
// DEBOUNCE_SCANS=3). Instance u_a has no repeat, u_b has REPEAT_SCANS=4.
// cyc counts rising edges since reset release; outputs are sampled on the
// falling edge, so "cycle n" is the cycle following edge n. Ticks fall in
// cycles with n%8 == 7 and their results show up in cycle n+1.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 3;
  localparam int unsigned SCAN = 8;
  localparam int unsigned DEB  = 3;

  logic       clock;
  logic       reset_n;
  logic [2:0] col, col_b;
  logic [3:0] row, row_b;
  logic [3:0] code, code_b;
  logic       valid, rep, held, rel;
  logic       valid_b, rep_b, held_b, rel_b;

  int total, bad, cyc;
  int a_vcnt, a_vcyc, a_rcnt, a_rcyc;
  logic [3:0] a_vcode;
  logic       a_vrep;
  int         b_vcyc[$];
  logic       b_vrep[$];
  logic [3:0] b_vcode[$];
  int         b_rcnt, b_rcyc;
  int         vcnt_before, rcnt_before;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_TICKS(SCAN),
    .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(0)
  ) u_a (
    .clock(clock), .reset_n(reset_n), .col(col), .row(row),
    .key_code(code), .key_valid(valid), .key_repeat(rep),
    .key_held(held), .key_release(rel)
  );

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_TICKS(SCAN),
    .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(4)
  ) u_b (
    .clock(clock), .reset_n(reset_n), .col(col_b), .row(row_b),
    .key_code(code_b), .key_valid(valid_b), .key_repeat(rep_b),
    .key_held(held_b), .key_release(rel_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and log any strobes seen there.
  task automatic cyc_step();
    @(negedge clock);
    if (valid) begin
      a_vcnt++;
      a_vcyc  = cyc;
      a_vcode = code;
      a_vrep  = rep;
    end
    if (rel) begin
      a_rcnt++;
      a_rcyc = cyc;
    end
    if (valid_b) begin
      b_vcyc.push_back(cyc);
      b_vrep.push_back(rep_b);
      b_vcode.push_back(code_b);
    end
    if (rel_b) begin
      b_rcnt++;
      b_rcyc = cyc;
    end
  endtask

  task automatic wait_until(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      cyc_step();
      guard++;
    end
    if (cyc < n) chk_eq("wait_bound", 32'(cyc), 32'(n));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    a_vcnt  = 0;
    a_rcnt  = 0;
    b_rcnt  = 0;
    reset_n = 1'b0;
    col     = 3'b000;
    col_b   = 3'b000;

    // Reset values
    repeat (3) cyc_step();
    chk_eq("rst_row", 32'(row), 32'd1);
    chk_eq("rst_code", 32'(code), 32'd0);
    chk_eq("rst_strobes", 32'({valid, rep, held, rel}), 32'd0);
    reset_n = 1'b1;

    // Free scan: row index = (n/8)%4, no strobes
    for (int k = 1; k <= 40; k++) begin
      cyc_step();
      chk_eq("scan_row", 32'(row), 32'(4'b0001 << ((k / 8) % 4)));
      chk_eq("scan_quiet", 32'({valid, rep, held, rel}), 32'd0);
    end

    // Press "5": row 0010 in cycles 40..47; qualifying ticks 47, 55, 63
    col = 3'b010;
    wait_until(70);
    chk_eq("p5_valid_cyc", 32'(a_vcyc), 32'(47 + (DEB - 1) * SCAN + 1));
    chk_eq("p5_code", 32'(a_vcode), 32'(KEY_5));
    chk_eq("p5_not_repeat", 32'(a_vrep), 32'd0);
    chk_eq("p5_held", 32'(held), 32'd1);
    chk_eq("p5_row_frozen", 32'(row), 32'b0010);
    wait_until(100);
    chk_eq("p5_single_valid", 32'(a_vcnt), 32'd1);

    // Release "5": col_s low from 102; low ticks 103, 111, 119
    col = 3'b000;
    wait_until(119);
    chk_eq("p5_held_before_rel", 32'(held), 32'd1);
    wait_until(120);
    chk_eq("p5_rel_cyc", 32'(a_rcyc), 32'd120);
    chk_eq("p5_held_cleared", 32'(held), 32'd0);
    chk_eq("p5_row_resume", 32'(row), 32'b0100);
    chk_eq("p5_code_holds", 32'(code), 32'(KEY_5));

    // Bounce on row0 (cycles 136..143): one qualifying tick at 143 only
    wait_until(137);
    col = 3'b001;
    wait_until(144);
    col = 3'b000;
    wait_until(148);
    chk_eq("bnc_row_frozen", 32'(row), 32'b0001);
    wait_until(152);
    chk_eq("bnc_row_adv", 32'(row), 32'b0010);
    wait_until(160);
    chk_eq("bnc_no_valid", 32'(a_vcnt), 32'd1);
    chk_eq("bnc_not_held", 32'(held), 32'd0);

    // Two keys in row 1000 (cycles 168..175): col0 wins -> KEY_STAR
    wait_until(169);
    col = 3'b101;
    wait_until(195);
    chk_eq("two_valid_cyc", 32'(a_vcyc), 32'd192);
    chk_eq("two_code", 32'(a_vcode), 32'(KEY_STAR));
    // Lift col0 only; col2 must be ignored until the release completes
    wait_until(200);
    col = 3'b100;
    wait_until(223);
    chk_eq("two_col2_ignored", 32'(a_vcnt), 32'd2);
    wait_until(224);
    chk_eq("two_rel_cyc", 32'(a_rcyc), 32'd224);
    chk_eq("two_row_wrap", 32'(row), 32'b0001);
    // Back in IDLE, col2 in row0 is captured at tick 231 -> KEY_3 at 248
    wait_until(250);
    chk_eq("two_next_cyc", 32'(a_vcyc), 32'd248);
    chk_eq("two_next_code", 32'(a_vcode), 32'(KEY_3));
    col = 3'b000;
    wait_until(275);
    chk_eq("two_rel_cnt", 32'(a_rcnt), 32'd3);
    chk_eq("two_code_holds", 32'(code), 32'(KEY_3));

    // Auto-repeat on u_b: row 1000 in cycles 280..287, hold "0"
    wait_until(280);
    col_b = 3'b010;
    wait_until(404);
    col_b = 3'b000;
    wait_until(430);
    chk_eq("rep_count", 32'(b_vcyc.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < b_vcyc.size()) begin
        chk_eq("rep_cyc", 32'(b_vcyc[i]), 32'(304 + 32 * i));
        chk_eq("rep_flag", 32'(b_vrep[i]), 32'(i > 0));
        chk_eq("rep_code", 32'(b_vcode[i]), 32'(KEY_0));
      end
    end
    chk_eq("rep_rel_cyc", 32'(b_rcyc), 32'd424);
    chk_eq("rep_a_quiet", 32'(a_vcnt), 32'd3);

    // Reset mid-debounce: qualifying ticks 447 and 455, reset at 458
    wait_until(440);
    col = 3'b001;
    wait_until(458);
    vcnt_before = a_vcnt;
    rcnt_before = a_rcnt;
    reset_n = 1'b0;
    #1;
    chk_eq("mid_rst_row", 32'(row), 32'd1);
    chk_eq("mid_rst_code", 32'(code), 32'd0);
    chk_eq("mid_rst_strobes", 32'({valid, rep, held, rel}), 32'd0);
    col = 3'b000;
    repeat (3) cyc_step();
    reset_n = 1'b1;
    wait_until(40);
    chk_eq("mid_rst_no_valid", 32'(a_vcnt), 32'(vcnt_before));
    chk_eq("mid_rst_no_rel", 32'(a_rcnt), 32'(rcnt_before));
    chk_eq("mid_rst_scan", 32'(row), 32'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised, debounced matrix-keypad scanner for the lock front end. Drives one-hot row strobes, samples and synchronises the column returns, and debounces a single key. Emits a key index with a one-cycle valid strobe, plus held, release and optional auto-repeat indications. Its output feeds the code-entry logic and the seven-segment display decoder.

## Interface
- ROWS, 4: number of keypad rows (≥2).
- COLS, 3: number of keypad columns (≥1).
- SCAN_TICKS, 5209: clock cycles per row slot (≥4).
- DEBOUNCE_SCANS, 4: consecutive qualifying ticks for press or release (≥1).
- REPEAT_SCANS, 0: ticks between auto-repeat strobes while held; 0 disables repeat.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- col  in  COLS  raw column returns, active-high, asynchronous to clock.
- row  out  ROWS  one-hot row drive, active-high.
- key_code  out  KEY_W  index = row_index*COLS + col_index, where KEY_W = $clog2(ROWS*COLS).
- key_valid  out  1  one-cycle strobe for a new press or a repeat.
- key_repeat  out  1  high with key_valid when the strobe is a repeat.
- key_held  out  1  level; debounced key currently down.
- key_release  out  1  one-cycle strobe when a debounced release completes.

## Operation
- Reset values: row = bit0 set, key_code = 0, all strobes and key_held = 0, FSM = IDLE, all counters = 0.
- col passes through a 2-flop synchroniser. All decisions use the synchronised value col_s.
- Tick counter runs 0..SCAN_TICKS-1 and wraps. A "tick" is the cycle in which the counter equals SCAN_TICKS-1. Decisions are made only on ticks.
- IDLE:
  - Row rotates bit0→bit1→…→bit(ROWS-1)→bit0 on each tick.
  - On a tick with any col_s bit high, capture the current row index and the lowest-index high column, set deb_cnt = 1, and go to DEBOUNCE. Do not advance the row.
- DEBOUNCE (row frozen):
  - Each tick, check only the captured column.
  - If high: deb_cnt++. When deb_cnt reaches DEBOUNCE_SCANS, load key_code, pulse key_valid, set key_held = 1, and go to HELD.
  - If low: return to IDLE and advance the row.
  - DEBOUNCE_SCANS = 1 means key_valid fires on the same tick as the capture.
- HELD (row frozen):
  - Captured column high: increment rep_cnt when REPEAT_SCANS > 0. At REPEAT_SCANS, pulse key_valid and key_repeat together, then clear rep_cnt.
  - Captured column low: go to RELEASE with deb_cnt = 1 and clear rep_cnt.
- RELEASE (row frozen):
  - Captured column low: deb_cnt++. At DEBOUNCE_SCANS, clear key_held, pulse key_release, go to IDLE, and advance the row.
  - Captured column high: return to HELD. No new key_valid.
- Other keys are ignored from capture until the FSM returns to IDLE, including keys in the same row.
- key_code holds its last value between presses.

## Timing
- Synchroniser latency is 2 cycles. col must be stable at least 2 cycles before a tick to count on that tick.
- key_valid, key_repeat and key_release are registered and high for exactly one cycle: the cycle after the deciding tick.
- key_held rises together with the first key_valid and falls together with key_release.
- Press latency, measured from the first qualifying tick to key_valid: (DEBOUNCE_SCANS-1)*SCAN_TICKS + 1 cycles.
- Row changes take effect the cycle after a tick.
- Asserting reset_n low at any point, including mid-DEBOUNCE, HELD or RELEASE, immediately forces the reset values. No strobe may be emitted for a key that was interrupted by reset.

## Structure
- Package keypad_pkg holds:
  - the FSM state enum (IDLE, DEBOUNCE, HELD, RELEASE);
  - the KEY_W function;
  - named 4×3 key-index constants: KEY_1 = 0 … KEY_9 = 8, KEY_STAR = 9, KEY_0 = 10, KEY_HASH = 11.
- One sub-module, keypad_col_sync: a 2-flop synchroniser, COLS wide, with asynchronous active-low reset to 0.
- Tick counter, FSM, debounce counter and repeat counter live in keypad_scanner.

## Test plan
Bench parameters: ROWS = 4, COLS = 3, SCAN_TICKS = 8, DEBOUNCE_SCANS = 3, REPEAT_SCANS = 0 unless stated.

- Reset and scan: release reset with col = 0, run 40 cycles → row sequence 0001, 0010, 0100, 1000, 0001, changing every 8 cycles; all strobes stay 0.
- Clean press of "5": hold col = 010 while row = 0010 → exactly one key_valid with key_code = 4, key_valid 17 cycles after the first qualifying tick, key_held = 1. Release → key_release after 3 low ticks, key_held = 0, rotation resumes at 0100.
- Bounce: assert col[0] in row0 for 1 tick, then 0 → no key_valid; FSM returns to IDLE and the row advances.
- Two keys down: col = 101 in row 1000 → key_code = 9 (KEY_STAR). col[2] is ignored until release.
- Auto-repeat with REPEAT_SCANS = 4: hold "0" (row 1000, col 010) → first key_valid with key_code = 10 and key_repeat = 0, then key_valid with key_repeat = 1 every 32 cycles.
- Reset mid-debounce: pull reset_n low after 2 qualifying ticks → immediate reset values; no key_valid after reset is released while col = 0.
